// File: rtl/egd_pkg.sv
// Shared types and default parameters for the order-0 Exp-Golomb decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package egd_pkg;

  // Default decoded-value width and largest supported leading-zero count.
  localparam int DATA_W_DEF     = 4;
  localparam int MAX_PREFIX_DEF = 4;

  // Decoder sequencing states.
  typedef enum logic [1:0] {
    SKIP   = 2'd0,
    PREFIX = 2'd1,
    SUFFIX = 2'd2,
    OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/egd_decoder.sv
// Serial ue(v) Exp-Golomb decoder: one code bit per cycle in, one DATA_W-bit value out.
// Latency: valid rises the cycle after the edge that consumed the last bit of a codeword.
// Backpressure: busy is high only in the OUT cycle; the source holds its bit across it.
module egd_decoder
  import egd_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_PREFIX = MAX_PREFIX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si_data,
  output logic [DATA_W-1:0] po_data,
  output logic              valid,
  output logic              busy
);

  // Counters are 3 bits wide, enough for a prefix of up to 7 zeros.
  localparam logic [2:0]    ZCNT_MAX = 3'(MAX_PREFIX);
  localparam logic [DATA_W:0] ONE    = {{DATA_W{1'b0}}, 1'b1};

  state_t              state;
  state_t              state_nxt;
  logic [2:0]          zcnt;
  logic [2:0]          zcnt_nxt;
  logic [2:0]          remaining;
  logic [2:0]          remaining_nxt;
  logic [DATA_W-1:0]   info;
  logic [DATA_W-1:0]   info_nxt;
  logic [DATA_W-1:0]   po_reg;
  logic [DATA_W-1:0]   po_nxt;
  logic [DATA_W:0]     value_sum;

  // Next-state, counter and result computation; the value is formed one edge
  // early so po_data is a plain register during the OUT cycle.
  always_comb begin
    state_nxt     = state;
    zcnt_nxt      = zcnt;
    remaining_nxt = remaining;
    info_nxt      = info;
    po_nxt        = po_reg;
    value_sum     = '0;
    case (state)
      SKIP: begin
        // The bit present in the first post-reset cycle is never trusted.
        state_nxt = PREFIX;
      end
      PREFIX: begin
        if (!si_data) begin
          // Saturate so an over-long prefix cannot wrap the counter.
          if (zcnt != ZCNT_MAX) begin
            zcnt_nxt = zcnt + 3'd1;
          end
        end else if (zcnt == 3'd0) begin
          po_nxt    = '0;
          state_nxt = OUT;
        end else begin
          info_nxt      = '0;
          remaining_nxt = zcnt;
          state_nxt     = SUFFIX;
        end
      end
      SUFFIX: begin
        info_nxt      = {info[DATA_W-2:0], si_data};
        remaining_nxt = remaining - 3'd1;
        if (remaining == 3'd1) begin
          // Oversized codes simply lose their carry here; there is no error flag.
          value_sum = (ONE << zcnt) - ONE + {1'b0, info_nxt};
          po_nxt    = value_sum[DATA_W-1:0];
          state_nxt = OUT;
        end
      end
      OUT: begin
        // No bit is consumed here; the held bit starts the next codeword.
        zcnt_nxt  = 3'd0;
        state_nxt = PREFIX;
      end
      default: begin
        state_nxt = SKIP;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SKIP;
      zcnt      <= 3'd0;
      remaining <= 3'd0;
      info      <= '0;
      po_reg    <= '0;
    end else begin
      state     <= state_nxt;
      zcnt      <= zcnt_nxt;
      remaining <= remaining_nxt;
      info      <= info_nxt;
      po_reg    <= po_nxt;
    end
  end

  // Moore outputs: strobe and stall come from state alone, never from si_data.
  always_comb begin
    valid   = (state == OUT);
    busy    = (state == OUT);
    po_data = po_reg;
  end

endmodule

// File: tb/tb_egd_decoder.sv
// Self-checking bench for egd_decoder: bit-string reference model plus per-cycle compare.
// Latency: n/a (testbench).
// Backpressure: the bit driver holds its bit after every edge at which busy was high.
module tb_egd_decoder;

  typedef struct packed {
    logic       v;
    logic       b;
    logic [3:0] p;
  } cyc_t;

  logic       clk;
  logic       rst;
  logic       si_data;
  logic [3:0] po_data;
  logic       valid;
  logic       busy;

  int   n_cmp;
  int   n_bad;
  logic chk_en;
  logic prev_valid;
  cyc_t exp_q[$];
  cyc_t cur;
  int   mdl_vals[$];
  int   got_q[$];
  int   lit_q[$];

  egd_decoder #(.DATA_W(4), .MAX_PREFIX(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .si_data (si_data),
    .po_data (po_data),
    .valid   (valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic void push_cyc(input logic v, input logic b, input int p);
    cyc_t c;
    c.v = v;
    c.b = b;
    c.p = 4'(p);
    exp_q.push_back(c);
  endfunction

  // Reference: parse the bit string as Exp-Golomb codes. Each complete code
  // costs 2N+1 idle cycles followed by one strobe/stall cycle carrying
  // (2^N - 1 + info) mod 16; po holds the last value elsewhere.
  task automatic model(input string s, input int tail);
    int i;
    int n;
    int info;
    int got;
    int v;
    int last;
    i    = 0;
    last = 0;
    exp_q.delete();
    mdl_vals.delete();
    while (i < s.len()) begin
      n = 0;
      while (i < s.len() && s[i] == "0") begin
        n++;
        i++;
        push_cyc(1'b0, 1'b0, last);
      end
      if (i >= s.len()) break;
      i++;
      push_cyc(1'b0, 1'b0, last);
      info = 0;
      got  = 0;
      while (got < n && i < s.len()) begin
        info = info * 2 + ((s[i] == "1") ? 1 : 0);
        i++;
        got++;
        push_cyc(1'b0, 1'b0, last);
      end
      if (got < n) break;
      v = ((1 << n) - 1 + info) % 16;
      push_cyc(1'b1, 1'b1, v);
      last = v;
      mdl_vals.push_back(v);
    end
    for (int k = 0; k < tail; k++) push_cyc(1'b0, 1'b0, last);
  endtask

  function automatic logic bit_at(input string s, input int idx);
    if (idx < s.len()) return (s[idx] == "1");
    return 1'b0;
  endfunction

  // Per-cycle comparison of DUT outputs against the reference timeline.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() == 0) begin
        chk("timeline_overrun", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("valid", int'(valid), int'(cur.v));
        chk("busy", int'(busy), int'(cur.b));
        chk("po_data", int'(po_data), int'(cur.p));
        chk("valid_twice", int'(valid && prev_valid), 0);
        if (valid) got_q.push_back(int'(po_data));
      end
      prev_valid <= valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  // Reset, pass the SKIP cycle with skip_bit on the line, then stream s.
  task automatic run_case(input string s, input logic skip_bit, input int tail);
    int   idx;
    int   total;
    logic b;
    model(s, tail);
    got_q.delete();
    total   = exp_q.size();
    rst     = 1'b1;
    si_data = 1'bx;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_po", int'(po_data), 0);
    rst     = 1'b0;
    si_data = skip_bit;
    @(posedge clk);
    #1;
    idx     = 0;
    si_data = bit_at(s, idx);
    chk_en  = 1'b1;
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      b = busy;
      @(posedge clk);
      #1;
      if (!b) idx++;
      si_data = bit_at(s, idx);
    end
    chk_en = 1'b0;
    chk("timeline_left", exp_q.size(), 0);
  endtask

  // Pin both the model and the DUT to hand-derived decoded values.
  task automatic check_lit(input string nm);
    chk({nm, "_model_n"}, mdl_vals.size(), lit_q.size());
    chk({nm, "_dut_n"}, got_q.size(), lit_q.size());
    for (int k = 0; k < lit_q.size(); k++) begin
      if (k < mdl_vals.size()) chk({nm, "_model_val"}, mdl_vals[k], lit_q[k]);
      if (k < got_q.size()) chk({nm, "_dut_val"}, got_q[k], lit_q[k]);
    end
  endtask

  initial begin
    string rs;
    int    n;
    int    info;
    n_cmp      = 0;
    n_bad      = 0;
    chk_en     = 1'b0;
    rst        = 1'b1;
    si_data    = 1'bx;

    run_case("1", 1'b1, 3);          lit_q = '{0};  check_lit("one");
    run_case("010", 1'b1, 3);        lit_q = '{1};  check_lit("c010");
    run_case("011", 1'bx, 3);        lit_q = '{2};  check_lit("c011_xskip");
    run_case("00111", 1'b1, 3);      lit_q = '{6};  check_lit("c00111");
    run_case("0001000", 1'b1, 3);    lit_q = '{7};  check_lit("c0001000");
    run_case("000010000", 1'b1, 3);  lit_q = '{15}; check_lit("c15");
    run_case("0001111", 1'b1, 3);    lit_q = '{14}; check_lit("c14");
    run_case("000011111", 1'b1, 3);  lit_q = '{14}; check_lit("wrap30");
    run_case("000010001", 1'b1, 3);  lit_q = '{0};  check_lit("wrap16");
    run_case("10100011000010000000100001", 1'b1, 3);
    lit_q = '{0, 1, 5, 7, 15, 0};
    check_lit("concat");

    // Partial prefix, then reset in the middle of the codeword.
    run_case("000", 1'b0, 0);
    run_case("1", 1'b1, 3);          lit_q = '{0};  check_lit("midrst");

    // Randomized codeword streams against the reference model.
    for (int r = 0; r < 4; r++) begin
      rs = "";
      for (int c = 0; c < 25; c++) begin
        n    = int'($urandom_range(0, 4));
        info = (n == 0) ? 0 : int'($urandom_range(0, (1 << n) - 1));
        for (int z = 0; z < n; z++) rs = {rs, "0"};
        rs = {rs, "1"};
        for (int j = n - 1; j >= 0; j--) rs = {rs, (((info >> j) & 1) != 0) ? "1" : "0"};
      end
      run_case(rs, logic'($urandom_range(0, 1)), 3);
      chk("rand_count", got_q.size(), mdl_vals.size());
      for (int k = 0; k < got_q.size() && k < mdl_vals.size(); k++)
        chk("rand_val", got_q[k], mdl_vals[k]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/egd_decoder.md
# egd_decoder

Serial order-0 Exponential-Golomb (ue(v)) decoder. It consumes a one-bit-per-cycle code stream, counts the leading-zero prefix, reads the info suffix and emits each decoded 4-bit value with a one-cycle `valid` strobe. `busy` is a flow-control output that tells the upstream bit source to hold its current bit. It sits directly behind a serial bitstream source and in front of any 4-bit symbol consumer.

## Interface
- `DATA_W`, 4: width of the decoded value; values 0..2^DATA_W−1.
- `MAX_PREFIX`, 4: largest supported leading-zero count.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `si_data`  in  1  serial code bit. It is X/Z during reset and in the first cycle after reset.
- `po_data`  out  DATA_W  decoded value; meaningful only while `valid`=1.
- `valid`  out  1  one-cycle strobe marking `po_data`.
- `busy`  out  1  when high at a rising edge, that edge does not consume `si_data` and the source must hold its bit.

## Operation
- Bit consumption rule: `si_data` is consumed at a rising edge if and only if `busy`=0 at that edge. The source presents a new bit after every edge at which `busy`=0, and repeats its bit after an edge at which `busy`=1.
- Code format: N zeros, then a 1, then N info bits (MSB first). The decoded value is 2^N − 1 + info.
- FSM states:
  - SKIP: entered on reset. Lasts 1 cycle, discards `si_data`, `busy`=0. Next state is PREFIX.
  - PREFIX: consumes a bit every cycle. On 0, zcnt++ (saturates at MAX_PREFIX). On 1 with zcnt=0, value=0 and next state is OUT. On 1 with zcnt>0, next state is SUFFIX with info cleared and remaining=zcnt.
  - SUFFIX: consumes a bit every cycle. info = {info, bit}, remaining−−. When remaining reaches 0, next state is OUT.
  - OUT: `valid`=1, `busy`=1, `po_data` = value; no bit is consumed. Then zcnt is cleared and next state is PREFIX.
- Arithmetic:
  - value = ((1<<zcnt) − 1) + info, computed in DATA_W+1 bits.
  - `po_data` is the low DATA_W bits of value. Codes wider than this (N=4 with info>0, or N>4) wrap silently; no error flag exists.
- Outputs are Moore outputs, registered or derived from state only; there is no combinational path from `si_data`.
- In OUT, `po_data` holds its value for the whole cycle. Outside OUT, `po_data` holds the last decoded value.

## Timing
- Reset values: state=SKIP, `valid`=0, `busy`=0, `po_data`=0, zcnt=0, info=0.
- `rst` asserted mid-codeword discards the partial code. The first post-reset edge is always SKIP.
- Latency: `valid` rises in the cycle right after the edge that consumed the codeword's final bit (the terminating 1 when N=0, otherwise the last info bit).
- Cost per codeword is 2N+1 consuming cycles plus 1 OUT cycle. `busy` is high exactly in the OUT cycles.
- Back-to-back codewords: the first bit of the next codeword is the bit held during OUT, and it is consumed at the edge that leaves OUT.
- `valid` is never high for two consecutive cycles.

## Structure
- `egd_pkg`: state enum {SKIP, PREFIX, SUFFIX, OUT}, plus the DATA_W and MAX_PREFIX defaults.
- Single module, with no sub-module. Contents: FSM, 3-bit zcnt, 3-bit remaining counter, DATA_W-bit info shift register, output register.

## Test plan
- Reset then stream "1": one `valid` pulse with `po_data`=0, occurring 1 cycle after the consuming edge; `busy`=1 only in that cycle.
- Streams "010", "011", "00111", "0001000": outputs 1, 2, 6, 7 respectively.
- "000010000" → 15. "0001111" → 14.
- Concatenated stream "1 010 00110 0001000 000010000 1": outputs 0, 1, 5, 7, 15, 0 in order, with no bit lost or duplicated across OUT cycles.
- Drive X on `si_data` in the cycle after reset: it is ignored and the decode of the following "011" gives 2.
- Assert `rst` after "000" of a codeword, then send "1": output 0. The partial state is discarded, `valid`/`busy` are 0 during reset, and the cycle after reset is SKIP.
